// File: rtl/emern_spi_cmd_rx.sv
// emern_spi_cmd_rx
// SPI mode-0 slave command engine. Byte 0 of a frame is a command
// (bit7 = write, low ADDR_W bits = start address); the following bytes are
// write data (turned into one-cycle register write strobes, gated by
// load_en) or read data (shifted out on MISO from the register file).
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   cs_n_in, sck_in,   asynchronous SPI pins, synchronized internally
//   mosi_in
//   miso_out           SPI data out (changes on synchronized sck fall)
//   load_en            1 = register writes permitted
//   wr_en/wr_addr/     one-cycle write strobe with address and data
//   wr_data
//   rd_addr/rd_data    read port to the register file (rd_data combinational)
//   frame_active       synchronized chip select asserted
//   drop_err           sticky per frame: a write byte was dropped
//   drop_cnt           saturating dropped-byte count
//
// Build option: define SPI_DROP_CNT_EN to implement drop_cnt as a
// saturating 8-bit counter cleared only by rst; otherwise it is tied to 0.
//
// state | meaning
// IDLE  | waiting for a synchronized cs_n fall
// CMD   | shifting in the command byte
// WDATA | shifting in write data bytes
// RDATA | shifting read data out on miso_out

module emern_spi_cmd_rx #(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n_in,
    input  logic              sck_in,
    input  logic              mosi_in,
    output logic              miso_out,
    input  logic              load_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              frame_active,
    output logic              drop_err,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_prev;
    logic                   sck_prev;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;
    logic                   cs_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_rise;
    logic                   sck_fall;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             rx_byte;
    logic [7:0]             tx_shift;
    logic [ADDR_W-1:0]      ptr;
    logic                   load_pending;
    logic                   drop_now;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign rx_byte  = {rx_shift, mosi_s};

    assign drop_now = (state == WDATA) && !cs_rise && sck_rise &&
                      (bit_cnt == 3'd7) && !load_en;

    // The cs_n chain resets to 1, so a pin held low through reset would look
    // like a fresh fall. A frame may only start once cs_n has been observed
    // high from real samples (fill marks when the chain holds real data).
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            cs_prev   <= cs_s;
            sck_prev  <= sck_s;
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            if (fill[SYNC_STAGES] && cs_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            miso_out     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rd_addr      <= '0;
            frame_active <= 1'b0;
            drop_err     <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            ptr          <= '0;
            load_pending <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (state == IDLE) begin
                if (armed && cs_fall) begin
                    state        <= CMD;
                    frame_active <= 1'b1;
                    drop_err     <= 1'b0;
                    bit_cnt      <= '0;
                end
            end else if (cs_rise) begin
                state        <= IDLE;
                frame_active <= 1'b0;
                miso_out     <= 1'b0;
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else if (sck_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    unique case (state)
                        CMD: begin
                            ptr          <= rx_byte[ADDR_W-1:0];
                            rd_addr      <= rx_byte[ADDR_W-1:0];
                            load_pending <= ~rx_byte[7];
                            state        <= rx_byte[7] ? WDATA : RDATA;
                        end
                        WDATA: begin
                            if (load_en) begin
                                wr_en   <= 1'b1;
                                wr_addr <= ptr;
                                wr_data <= rx_byte;
                            end else begin
                                drop_err <= 1'b1;
                            end
                            ptr <= ptr + ADDR_W'(1);
                        end
                        RDATA: begin
                            // rd_addr settles long before the next fall loads it
                            ptr          <= ptr + ADDR_W'(1);
                            rd_addr      <= ptr + ADDR_W'(1);
                            load_pending <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (sck_fall && state == RDATA) begin
                if (load_pending) begin
                    miso_out     <= rd_data[7];
                    tx_shift     <= {rd_data[6:0], 1'b0};
                    load_pending <= 1'b0;
                end else begin
                    miso_out <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

`ifdef SPI_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop_now && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_emern_spi_cmd_rx.sv
module tb_emern_spi_cmd_rx;
    localparam int ADDR_W = 5;
    localparam int H      = 8;   // sck half period in clk cycles

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_n, sck, mosi, load_en;
    logic              miso_out, wr_en, frame_active, drop_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [7:0]        wr_data, rd_data, drop_cnt;
    logic [7:0]        mem [32];

    emern_spi_cmd_rx #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs_n_in(cs_n), .sck_in(sck), .mosi_in(mosi),
        .miso_out(miso_out), .load_en(load_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_active(frame_active), .drop_err(drop_err),
        .drop_cnt(drop_cnt)
    );

    assign rd_data = mem[rd_addr];
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  drops = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int exp_drop_cnt();
`ifdef SPI_DROP_CNT_EN
        return (drops > 255) ? 255 : drops;
`else
        return 0;
`endif
    endfunction

    // Write-strobe monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, input int nbits = 8);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(H);
            rx[i] = miso_out;
            sck = 1'b1;
            wait_clk(H);
            sck = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clk(H);
    endtask

    task automatic frame_end();
        wait_clk(H);
        cs_n = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(miso_out),     0);
        check({tag, "_wr_en"},    32'(wr_en),        0);
        check({tag, "_wr_addr"},  32'(wr_addr),      0);
        check({tag, "_wr_data"},  32'(wr_data),      0);
        check({tag, "_rd_addr"},  32'(rd_addr),      0);
        check({tag, "_active"},   32'(frame_active), 0);
        check({tag, "_drop_err"}, 32'(drop_err),     0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt),     0);
    endtask

    task automatic write_frame(input logic [ADDR_W-1:0] a, input logic [7:0] d[$],
                               input logic le[$]);
        logic [7:0]        rx;
        logic [ADDR_W-1:0] p;
        bit                any_drop;
        wr_t               e;
        p = a;
        any_drop = 0;
        frame_start();
        spi_byte({1'b1, 2'($urandom), a}, rx);
        check("active_mid_write", 32'(frame_active), 1);
        foreach (d[i]) begin
            load_en = le[i];
            if (le[i]) begin
                e.a = p;
                e.d = d[i];
                exp_q.push_back(e);
            end else begin
                drops++;
                any_drop = 1;
            end
            p = p + ADDR_W'(1);
            spi_byte(d[i], rx);
        end
        frame_end();
        load_en = 1'b1;
        check("drop_err", 32'(drop_err), 32'(any_drop));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt()));
        check("active_after_write", 32'(frame_active), 0);
    endtask

    task automatic read_frame(input logic [ADDR_W-1:0] a, input int n);
        logic [7:0] rx;
        frame_start();
        spi_byte({1'b0, 2'($urandom), a}, rx);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), rx);
            check("read_byte", 32'(rx), 32'(mem[5'(a + i)]));
        end
        frame_end();
        check("miso_after_read", 32'(miso_out), 0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] dq[$];
        logic       lq[$];

        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; load_en = 1'b1;
        foreach (mem[i]) mem[i] = 8'($urandom);
        mem[31] = 8'hA5;
        mem[0]  = 8'h3C;
        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(6);

        // basic write frame, both bytes accepted
        write_frame(5'd3, '{8'h2A, 8'h15}, '{1'b1, 1'b1});
        // second byte outside the blanking interval
        write_frame(5'd3, '{8'h2A, 8'h15}, '{1'b1, 1'b0});
        // read across the address wrap 31 -> 0
        read_frame(5'd31, 2);

        // abort after 5 bits of a data byte, then a clean frame
        frame_start();
        spi_byte(8'h85, rx);
        spi_byte(8'hFF, rx, 5);
        cs_n = 1'b1;
        wait_clk(2 * H);
        check("abort_active", 32'(frame_active), 0);
        check("abort_drop_err", 32'(drop_err), 0);
        write_frame(5'd1, '{8'h77}, '{1'b1});

        // reset mid-frame: rest of the frame must be ignored
        frame_start();
        spi_byte(8'h89, rx);
        spi_byte(8'h55, rx, 4);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        drops = 0;
        check_reset_outputs("midrst");
        spi_byte(8'h0F, rx, 4);
        spi_byte(8'hC3, rx);
        spi_byte(8'h81, rx);
        frame_end();
        check("midrst_active", 32'(frame_active), 0);
        write_frame(5'd9, '{8'hC3}, '{1'b1});

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            logic [ADDR_W-1:0] a;
            int                n;
            a = ADDR_W'($urandom);
            n = 1 + int'($urandom_range(3));
            if ($urandom_range(1) == 1) begin
                dq.delete();
                lq.delete();
                for (int i = 0; i < n; i++) begin
                    dq.push_back(8'($urandom));
                    lq.push_back($urandom_range(3) != 0);
                end
                write_frame(a, dq, lq);
            end else begin
                read_frame(a, n);
            end
        end

        // 300 dropped bytes saturate the counter; rst clears it
        dq.delete();
        lq.delete();
        for (int i = 0; i < 300; i++) begin
            dq.push_back(8'($urandom));
            lq.push_back(1'b0);
        end
        write_frame(5'd0, dq, lq);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        drops = 0;
        check("drop_cnt_after_rst", 32'(drop_cnt), 0);
        check("drop_err_after_rst", 32'(drop_err), 0);

        wait_clk(4 * H);
        check("pending_writes", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
